// File: rtl/const_seq_ctrl.sv
// Sequencer for a constant-step accumulator: clears it, enables it for n cycles,
// then compares the accumulator value against the locally tracked expected sum.
module const_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int STEP  = 5,
  parameter int NW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NW-1:0]    n,
  input  logic             abort,
  input  logic [WIDTH-1:0] c_in,
  output logic             conen,
  output logic             conclr,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4,
    S_ABORT = 3'd5
  } state_t;

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  state_t           state_q,  state_d;
  logic [NW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] exp_q,    exp_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q,    err_d;
  logic             conen_q,  conen_d;
  logic             conclr_q, conclr_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  // Next-state, counter, expected-sum and check capture logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    exp_d    = exp_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          cnt_d   = n;
          err_d   = 1'b0;
          exp_d   = {WIDTH{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (abort) begin
          state_d = S_ABORT;
        end else if (cnt_q == {NW{1'b0}}) begin
          state_d = S_CHECK;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q - {{(NW-1){1'b0}}, 1'b1};
          exp_d = exp_q + STEP_W;
          // cnt_q is never zero here, so the last RUN cycle sees one.
          if (cnt_q == {{(NW-1){1'b0}}, 1'b1}) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_CHECK: begin
        if (abort) begin
          state_d = S_ABORT;
        end else begin
          state_d  = S_DONE;
          result_d = c_in;
          err_d    = (c_in != exp_q);
        end
      end
      S_DONE: begin
        if (abort) begin
          state_d = S_ABORT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs are decoded from the next state so they register with it.
  always_comb begin
    conen_d  = (state_d == S_RUN);
    conclr_d = (state_d == S_CLEAR) || (state_d == S_ABORT);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
  end

  // State and registered outputs; reset forces a quiet idle immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= {NW{1'b0}};
      exp_q    <= {WIDTH{1'b0}};
      result_q <= {WIDTH{1'b0}};
      err_q    <= 1'b0;
      conen_q  <= 1'b0;
      conclr_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      exp_q    <= exp_d;
      result_q <= result_d;
      err_q    <= err_d;
      conen_q  <= conen_d;
      conclr_q <= conclr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign conen  = conen_q;
  assign conclr = conclr_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;

endmodule

// File: tb/tb_const_seq_ctrl.sv
// Directed bench for const_seq_ctrl with a behavioural step-5 accumulator attached.
module tb_const_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  n = 8'd0;
  logic        abort = 1'b0;
  logic [15:0] c_in;
  logic        conen, conclr, busy, done, err;
  logic [15:0] result;

  logic [15:0] acc;
  logic        stuck = 1'b0;
  logic [15:0] stuck_val = 16'd0;

  int total = 0;
  int bad   = 0;

  const_seq_ctrl #(.WIDTH(16), .STEP(5), .NW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .n(n), .abort(abort), .c_in(c_in),
    .conen(conen), .conclr(conclr), .busy(busy), .done(done), .err(err), .result(result)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         acc <= 16'd0;
    else if (conclr) acc <= 16'd0;
    else if (conen)  acc <= acc + 16'd5;
  end

  assign c_in = stuck ? stuck_val : acc;

  // Pulses start (and optionally again at cycle repeat_at) and tallies outputs until idle.
  task automatic do_run(input logic [7:0] nv, input int repeat_at,
                        output int n_clr, output int n_en, output int n_done,
                        output int done_cyc, output int n_both);
    int cyc;
    n_clr = 0; n_en = 0; n_done = 0; n_both = 0; done_cyc = -1;
    start = 1'b1; n = nv;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    cyc = 1;
    while (cyc < 600) begin
      if (conclr) n_clr++;
      if (conen) n_en++;
      if (conen && conclr) n_both++;
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (!busy) break;
      start = (cyc == repeat_at);
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
  endtask

  task automatic test_reset();
    #3;
    total++; if (conen !== 1'b0)  begin bad++; $display("FAIL reset_conen: got %b want 0", conen); end
    total++; if (conclr !== 1'b0) begin bad++; $display("FAIL reset_conclr: got %b want 0", conclr); end
    total++; if (busy !== 1'b0)   begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0)   begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (err !== 1'b0)    begin bad++; $display("FAIL reset_err: got %b want 0", err); end
    total++; if (result !== 16'd0) begin bad++; $display("FAIL reset_result: got %0d want 0", result); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_n3();
    int c, e, d, dc, b;
    do_run(8'd3, -1, c, e, d, dc, b);
    total++; if (c !== 1)  begin bad++; $display("FAIL n3_conclr_cycles: got %0d want 1", c); end
    total++; if (e !== 3)  begin bad++; $display("FAIL n3_conen_cycles: got %0d want 3", e); end
    total++; if (d !== 1)  begin bad++; $display("FAIL n3_done_pulses: got %0d want 1", d); end
    total++; if (dc !== 6) begin bad++; $display("FAIL n3_done_cycle: got %0d want 6", dc); end
    total++; if (b !== 0)  begin bad++; $display("FAIL n3_overlap: got %0d want 0", b); end
    total++; if (result !== 16'd15) begin bad++; $display("FAIL n3_result: got %0d want 15", result); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL n3_err: got %b want 0", err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL n3_idle: got busy %b want 0", busy); end
  endtask

  task automatic test_abort();
    start = 1'b1; n = 8'd5;
    @(posedge clk); #1; start = 1'b0;
    total++; if (conclr !== 1'b1) begin bad++; $display("FAIL abort_clear: got %b want 1", conclr); end
    repeat (2) begin @(posedge clk); #1; end
    total++; if (conen !== 1'b1) begin bad++; $display("FAIL abort_in_run: got %b want 1", conen); end
    abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    total++; if (conen !== 1'b0)  begin bad++; $display("FAIL abort_conen: got %b want 0", conen); end
    total++; if (conclr !== 1'b1) begin bad++; $display("FAIL abort_conclr: got %b want 1", conclr); end
    total++; if (done !== 1'b0)   begin bad++; $display("FAIL abort_done: got %b want 0", done); end
    total++; if (busy !== 1'b1)   begin bad++; $display("FAIL abort_busy1: got %b want 1", busy); end
    @(posedge clk); #1;
    total++; if (busy !== 1'b0)   begin bad++; $display("FAIL abort_busy2: got %b want 0", busy); end
    total++; if (conclr !== 1'b0) begin bad++; $display("FAIL abort_conclr2: got %b want 0", conclr); end
    total++; if (done !== 1'b0)   begin bad++; $display("FAIL abort_done2: got %b want 0", done); end
    total++; if (result !== 16'd15) begin bad++; $display("FAIL abort_result: got %0d want 15", result); end
    total++; if (err !== 1'b0)    begin bad++; $display("FAIL abort_err: got %b want 0", err); end
  endtask

  task automatic test_n0();
    int c, e, d, dc, b;
    abort = 1'b1;  // abort in IDLE alongside start must not block the start
    do_run(8'd0, -1, c, e, d, dc, b);
    total++; if (c !== 1)  begin bad++; $display("FAIL n0_conclr_cycles: got %0d want 1", c); end
    total++; if (e !== 0)  begin bad++; $display("FAIL n0_conen_cycles: got %0d want 0", e); end
    total++; if (dc !== 3) begin bad++; $display("FAIL n0_done_cycle: got %0d want 3", dc); end
    total++; if (result !== 16'd0) begin bad++; $display("FAIL n0_result: got %0d want 0", result); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL n0_err: got %b want 0", err); end
  endtask

  task automatic test_stuck();
    int c, e, d, dc, b;
    stuck = 1'b1; stuck_val = 16'd7;
    do_run(8'd2, -1, c, e, d, dc, b);
    total++; if (err !== 1'b1)     begin bad++; $display("FAIL stuck_err: got %b want 1", err); end
    total++; if (result !== 16'd7) begin bad++; $display("FAIL stuck_result: got %0d want 7", result); end
    total++; if (dc !== 5)         begin bad++; $display("FAIL stuck_done_cycle: got %0d want 5", dc); end
    stuck = 1'b0;
    start = 1'b1; n = 8'd1;
    @(posedge clk); #1; start = 1'b0;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL stuck_err_cleared: got %b want 0", err); end
    repeat (4) begin @(posedge clk); #1; end
    total++; if (result !== 16'd5) begin bad++; $display("FAIL stuck_rerun_result: got %0d want 5", result); end
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL stuck_rerun_idle: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int c, e, d, dc, b;
    do_run(8'd255, 10, c, e, d, dc, b);
    total++; if (e !== 255)  begin bad++; $display("FAIL long_conen_cycles: got %0d want 255", e); end
    total++; if (c !== 1)    begin bad++; $display("FAIL long_conclr_cycles: got %0d want 1", c); end
    total++; if (d !== 1)    begin bad++; $display("FAIL long_done_pulses: got %0d want 1", d); end
    total++; if (dc !== 258) begin bad++; $display("FAIL long_done_cycle: got %0d want 258", dc); end
    total++; if (result !== 16'd1275) begin bad++; $display("FAIL long_result: got %0d want 1275", result); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL long_err: got %b want 0", err); end
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL long_stays_idle: got %b want 0", busy); end
  endtask

  task automatic test_async_reset();
    int c, e, d, dc, b;
    start = 1'b1; n = 8'd4;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    total++; if (conen !== 1'b1) begin bad++; $display("FAIL areset_in_run: got %b want 1", conen); end
    #2 rst = 1'b1;
    #1;
    total++; if (conen !== 1'b0)  begin bad++; $display("FAIL areset_conen: got %b want 0", conen); end
    total++; if (conclr !== 1'b0) begin bad++; $display("FAIL areset_conclr: got %b want 0", conclr); end
    total++; if (busy !== 1'b0)   begin bad++; $display("FAIL areset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0)   begin bad++; $display("FAIL areset_done: got %b want 0", done); end
    total++; if (err !== 1'b0)    begin bad++; $display("FAIL areset_err: got %b want 0", err); end
    total++; if (result !== 16'd0) begin bad++; $display("FAIL areset_result: got %0d want 0", result); end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    total++; if (conclr !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL areset_quiet: got conclr=%b busy=%b want 0 0", conclr, busy);
    end
    do_run(8'd3, -1, c, e, d, dc, b);
    total++; if (e !== 3)  begin bad++; $display("FAIL areset_rerun_conen: got %0d want 3", e); end
    total++; if (dc !== 6) begin bad++; $display("FAIL areset_rerun_done: got %0d want 6", dc); end
    total++; if (result !== 16'd15) begin bad++; $display("FAIL areset_rerun_result: got %0d want 15", result); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL areset_rerun_err: got %b want 0", err); end
  endtask

  initial begin
    test_reset();
    test_n3();
    test_abort();
    test_n0();
    test_stuck();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
